// File: rtl/jump_pkg.sv
// Shared types and widths for the player jump physics.
package jump_pkg;

  localparam int H_W = 10;  // height / scan-coordinate width
  localparam int V_W = 8;   // signed vertical velocity width

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    RISING   = 2'd1,
    FALLING  = 2'd2
  } jump_state_e;

endpackage

// File: rtl/jump_frame_tick.sv
// One-cycle frame tick: fires on the first clock where the scan position
// equals (TICK_X, TICK_Y), however many cycles that position is held.
module jump_frame_tick
  import jump_pkg::*;
#(
  parameter int TICK_X = 1,
  parameter int TICK_Y = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [H_W-1:0] i_x_cord,
  input  logic [H_W-1:0] i_y_cord,
  output logic           o_tick
);

  localparam logic [H_W-1:0] TX = H_W'(TICK_X);
  localparam logic [H_W-1:0] TY = H_W'(TICK_Y);

  logic hit;
  logic hit_d;
  logic hit_q;

  assign hit    = (i_x_cord == TX) && (i_y_cord == TY);
  assign o_tick = hit & ~hit_q;

  // Remember last cycle's match so the tick marks only its leading edge.
  always_comb begin
    hit_d = hit;
  end

  // Match history register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit_q <= 1'b0;
    else        hit_q <= hit_d;
  end

endmodule

// File: rtl/jump_controller.sv
// Per-frame vertical physics for the player sprite: a jump press launches
// the sprite, gravity is integrated once per frame, height is clamped at a
// ceiling, and everything holds while the game is frozen.
module jump_controller
  import jump_pkg::*;
#(
  parameter int V0         = 12,
  parameter int GRAVITY    = 1,
  parameter int MAX_HEIGHT = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  i_x_cord,
  input  logic [9:0]  i_y_cord,
  input  logic        i_jump,
  input  logic        i_freeze,
  output logic [9:0]  o_height,
  output logic        o_jumping,
  output logic        o_land
);

  // Two guard bits so height + velocity can never wrap, even near a
  // ceiling close to the top of the height range.
  localparam int S_W = H_W + 2;

  localparam logic signed [V_W-1:0] V0_V   = V_W'(V0);
  localparam logic signed [V_W-1:0] GRAV_V = V_W'(GRAVITY);
  localparam logic signed [V_W-1:0] ZERO_V = '0;
  localparam logic signed [S_W-1:0] ZERO_S = '0;
  localparam logic signed [S_W-1:0] MAX_S  = S_W'(MAX_HEIGHT);
  localparam logic [H_W-1:0]        MAX_H  = H_W'(MAX_HEIGHT);

  jump_state_e            state_d, state_q;
  logic [H_W-1:0]         height_d, height_q;
  logic signed [V_W-1:0]  vel_d, vel_q;
  logic                   jumping_d, jumping_q;
  logic                   land_d, land_q;
  logic                   pend_d, pend_q;
  logic                   jump_prev_d, jump_prev_q;

  logic                   tick;
  logic                   step;
  logic                   jump_edge;
  logic signed [S_W-1:0]  h_next;
  logic signed [V_W-1:0]  vel_dec;

  jump_frame_tick #(
    .TICK_X (1),
    .TICK_Y (1)
  ) u_frame_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_x_cord (i_x_cord),
    .i_y_cord (i_y_cord),
    .o_tick   (tick)
  );

  assign step      = tick & ~i_freeze;
  assign jump_edge = i_jump & ~jump_prev_q;
  assign h_next    = $signed({2'b00, height_q})
                   + $signed({{(S_W - V_W){vel_q[V_W-1]}}, vel_q});
  assign vel_dec   = vel_q - GRAV_V;

  // Next-state logic: jump request flag, then one physics step per unfrozen tick.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    height_d    = height_q;
    vel_d       = vel_q;
    jumping_d   = jumping_q;
    land_d      = 1'b0;
    pend_d      = pend_q;
    jump_prev_d = i_jump;

    // A press is remembered only while grounded; freeze drops it.
    if (i_freeze) begin
      pend_d = 1'b0;
    end else if (step && (state_q == GROUNDED) && pend_q) begin
      pend_d = 1'b0;
    end else if (jump_edge) begin
      pend_d = (state_q == GROUNDED);
    end

    if (step) begin
      case (state_q)
        GROUNDED: begin
          if (pend_q) begin
            vel_d    = V0_V;
            height_d = '0;
            state_d  = RISING;
          end
        end
        RISING, FALLING: begin
          if (h_next <= ZERO_S) begin
            height_d = '0;
            vel_d    = ZERO_V;
            state_d  = GROUNDED;
            land_d   = 1'b1;
          end else if (h_next > MAX_S) begin
            height_d = MAX_H;
            vel_d    = ZERO_V;
            state_d  = FALLING;
          end else begin
            height_d = h_next[H_W-1:0];
            vel_d    = vel_dec;
            if ((state_q == RISING) && (vel_dec <= ZERO_V)) state_d = FALLING;
          end
        end
        default: begin
          state_d  = GROUNDED;
          height_d = '0;
          vel_d    = ZERO_V;
        end
      endcase
      jumping_d = (state_d != GROUNDED);
    end
  end

  // State and output registers; async reset returns straight to the ground.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= GROUNDED;
      height_q    <= '0;
      vel_q       <= ZERO_V;
      jumping_q   <= 1'b0;
      land_q      <= 1'b0;
      pend_q      <= 1'b0;
      jump_prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values regardless of statement order.
      state_q     <= state_d;
      height_q    <= height_d;
      vel_q       <= vel_d;
      jumping_q   <= jumping_d;
      land_q      <= land_d;
      pend_q      <= pend_d;
      jump_prev_q <= jump_prev_d;
    end
  end

  assign o_height  = height_q;
  assign o_jumping = jumping_q;
  assign o_land    = land_q;

endmodule

// File: tb/tb_jump_controller.sv
// Directed bench for jump_controller: a default instance and a low-ceiling
// instance (MAX_HEIGHT=45) driven by the same stimulus.
module tb_jump_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] x_cord, y_cord;
  logic       i_jump, i_freeze;
  logic [9:0] o_height, hc;
  logic       o_jumping, jc;
  logic       o_land, lc;

  always #5 clk = ~clk;

  jump_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_x_cord  (x_cord),
    .i_y_cord  (y_cord),
    .i_jump    (i_jump),
    .i_freeze  (i_freeze),
    .o_height  (o_height),
    .o_jumping (o_jumping),
    .o_land    (o_land)
  );

  jump_controller #(.MAX_HEIGHT(45)) dut_c (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_x_cord  (x_cord),
    .i_y_cord  (y_cord),
    .i_jump    (i_jump),
    .i_freeze  (i_freeze),
    .o_height  (hc),
    .o_jumping (jc),
    .o_land    (lc)
  );

  typedef struct {
    logic       jump;   // i_jump level during this frame
    int         hold;   // cycles the tick coordinate is held
    logic [9:0] h;      // expected default-instance height after the frame
    logic       j;
    int         land;   // expected o_land high cycles within the frame
    logic [9:0] h_c;    // expected low-ceiling instance values
    logic       j_c;
    int         land_c;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   land_n, land_cn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic jump, input int hold, input int h, input logic j, input int land,
                     input int h_c, input logic j_c, input int land_c);
    vec_t v;
    v.jump = jump; v.hold = hold; v.h = 10'(h); v.j = j; v.land = land;
    v.h_c = 10'(h_c); v.j_c = j_c; v.land_c = land_c;
    vecs.push_back(v);
  endtask

  // One video frame: tick coordinate held 'hold' cycles, then 3 other cycles.
  // Called at a negedge; counts o_land cycles of both instances.
  task automatic frame(input int hold);
    land_n  = 0;
    land_cn = 0;
    x_cord  = 10'd1;
    y_cord  = 10'd1;
    for (int i = 0; i < hold + 3; i++) begin
      @(negedge clk);
      land_n  += int'(o_land);
      land_cn += int'(lc);
      if (i == hold - 1) begin
        x_cord = 10'd5;
        y_cord = 10'd5;
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    x_cord   = 10'd5;
    y_cord   = 10'd5;
    i_jump   = 1'b0;
    i_freeze = 1'b0;

    // Reset state.
    #12;
    check("reset_height", 32'(o_height), 0);
    check("reset_jumping", 32'(o_jumping), 0);
    check("reset_land", 32'(o_land), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full arc (default) and ceiling arc (MAX_HEIGHT=45); button held through
    // landing, released at step 5 and re-pressed mid-air at step 6.
    // Step 3 holds the tick coordinate 5 cycles: still one update.
    //   jump hold  h   j land  h_c j_c land_c
    add(1, 1,   0, 1, 0,   0, 1, 0);   // launch tick
    add(1, 1,  12, 1, 0,  12, 1, 0);
    add(1, 1,  23, 1, 0,  23, 1, 0);
    add(1, 5,  33, 1, 0,  33, 1, 0);
    add(1, 1,  42, 1, 0,  42, 1, 0);
    add(0, 1,  50, 1, 0,  45, 1, 0);   // ceiling clamp
    add(1, 1,  57, 1, 0,  45, 1, 0);   // mid-air press ignored
    add(1, 1,  63, 1, 0,  44, 1, 0);
    add(1, 1,  68, 1, 0,  42, 1, 0);
    add(1, 1,  72, 1, 0,  39, 1, 0);
    add(1, 1,  75, 1, 0,  35, 1, 0);
    add(1, 1,  77, 1, 0,  30, 1, 0);
    add(1, 1,  78, 1, 0,  24, 1, 0);   // peak
    add(1, 1,  78, 1, 0,  17, 1, 0);   // peak again
    add(1, 1,  77, 1, 0,   9, 1, 0);
    add(1, 1,  75, 1, 0,   0, 0, 1);   // ceiling arc lands
    add(1, 1,  72, 1, 0,   0, 0, 0);
    add(1, 1,  68, 1, 0,   0, 0, 0);
    add(1, 1,  63, 1, 0,   0, 0, 0);
    add(1, 1,  57, 1, 0,   0, 0, 0);
    add(1, 1,  50, 1, 0,   0, 0, 0);
    add(1, 1,  42, 1, 0,   0, 0, 0);
    add(1, 1,  33, 1, 0,   0, 0, 0);
    add(1, 1,  23, 1, 0,   0, 0, 0);
    add(1, 1,  12, 1, 0,   0, 0, 0);
    add(1, 1,   0, 0, 1,   0, 0, 0);   // landing, one-cycle pulse
    add(1, 1,   0, 0, 0,   0, 0, 0);   // held button: no relaunch
    add(1, 1,   0, 0, 0,   0, 0, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      i_jump = vecs[k].jump;
      @(negedge clk);
      frame(vecs[k].hold);
      check($sformatf("arc%0d_height", k), 32'(o_height), 32'(vecs[k].h));
      check($sformatf("arc%0d_jumping", k), 32'(o_jumping), 32'(vecs[k].j));
      check($sformatf("arc%0d_land", k), 32'(land_n), 32'(vecs[k].land));
      check($sformatf("arc%0d_height_c", k), 32'(hc), 32'(vecs[k].h_c));
      check($sformatf("arc%0d_jumping_c", k), 32'(jc), 32'(vecs[k].j_c));
      check($sformatf("arc%0d_land_c", k), 32'(land_cn), 32'(vecs[k].land_c));
    end

    // Press while frozen on the ground is dropped.
    i_jump = 1'b0;
    @(negedge clk);
    i_freeze = 1'b1;
    frame(1);
    i_jump = 1'b1;
    frame(1);
    i_freeze = 1'b0;
    frame(1);
    check("gfrz_jumping", 32'(o_jumping), 0);
    frame(1);
    check("gfrz_jumping2", 32'(o_jumping), 0);
    check("gfrz_height", 32'(o_height), 0);
    i_jump = 1'b0;
    @(negedge clk);

    // Freeze mid-air at 33 for 10 frames, then resume to 42.
    i_jump = 1'b1;
    @(negedge clk);
    frame(1);
    check("afrz_launch", 32'(o_jumping), 1);
    i_jump = 1'b0;
    frame(1);
    frame(1);
    frame(1);
    check("afrz_pre", 32'(o_height), 33);
    i_freeze = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) i_jump = 1'b1;
      if (k == 6) i_jump = 1'b0;
      frame(1);
      check($sformatf("afrz%0d_height", k), 32'(o_height), 33);
    end
    check("afrz_jumping", 32'(o_jumping), 1);
    i_freeze = 1'b0;
    frame(1);
    check("afrz_resume", 32'(o_height), 42);
    check("afrz_resume_c", 32'(hc), 42);

    // Asynchronous reset mid-air, away from any clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_height", 32'(o_height), 0);
    check("mid_rst_jumping", 32'(o_jumping), 0);
    check("mid_rst_land", 32'(o_land), 0);
    check("mid_rst_height_c", 32'(hc), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Jump edge in the same cycle as the tick: launch on the following tick.
    i_jump = 1'b1;
    frame(1);
    check("coinc_no_launch", 32'(o_jumping), 0);
    frame(1);
    check("coinc_launch", 32'(o_jumping), 1);
    check("coinc_launch_h", 32'(o_height), 0);
    frame(1);
    check("coinc_tick1", 32'(o_height), 12);
    i_jump = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
